sv_pipeline_rs: RTL

- Parametrised valid/ready register slice pipeline; generalises the plain enable-gated data register to a handshaked, multi-stage, mode-selectable slice.
- Inserted on AXI channel paths (AW/W/B/AR/R) around the arbiter to break timing on data/valid and, optionally, ready.
- Lossless, in-order, throughput of 1 beat/cycle in every mode.

---
 rtl/sv_pipeline_pkg.sv | 22 ++
 rtl/sv_rs_stage.sv | 112 +++++++++++
 rtl/sv_pipeline_rs.sv | 97 +++++++++
 3 files changed

// File: rtl/sv_pipeline_pkg.sv
// Shared types for the sv_pipeline_rs register-slice pipeline.
// Holds the slice mode selector, the per-stage state encoding and the occupancy width helper.
package sv_pipeline_pkg;

    typedef enum logic [1:0] {
        RS_BYPASS,
        RS_FWD,
        RS_FULL
    } rs_mode_e;

    typedef enum logic [1:0] {
        RS_EMPTY,
        RS_BUSY,
        RS_FULLST
    } rs_state_e;

    // Counter width that can hold 0..2*stages beats.
    function automatic int occ_width(input int stages);
        return $clog2(2 * stages + 1);
    endfunction

endpackage

// File: rtl/sv_rs_stage.sv
// One valid/ready slice stage: RS_FWD is a single register with a combinational ready,
// RS_FULL is a main + skid pair with a registered ready (no combinational path either way).
module sv_rs_stage
    import sv_pipeline_pkg::*;
#(
    parameter int       WIDTH = 32,
    parameter rs_mode_e MODE  = RS_FULL
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    generate
        if (MODE == RS_FWD) begin : g_fwd
            logic             valid_q, valid_d;
            logic [WIDTH-1:0] data_q, data_d;

            assign in_ready_o  = !valid_q || out_ready_i;
            assign out_valid_o = valid_q;
            assign out_data_o  = data_q;

            always_comb begin
                valid_d = valid_q;
                data_d  = data_q;
                if (in_valid_i && in_ready_o) begin
                    valid_d = 1'b1;
                    data_d  = in_data_i;
                end else if (out_ready_i) begin
                    valid_d = 1'b0;
                end
                if (flush_i) valid_d = 1'b0;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    valid_q <= 1'b0;
                    data_q  <= '0;
                end else begin
                    valid_q <= valid_d;
                    data_q  <= data_d;
                end
            end
        end else begin : g_full
            rs_state_e        state_q, state_d;
            logic             ready_q;
            logic [WIDTH-1:0] main_q, main_d;
            logic [WIDTH-1:0] skid_q, skid_d;
            logic             in_xfer, out_xfer;

            assign in_ready_o  = ready_q;
            assign out_valid_o = (state_q != RS_EMPTY);
            assign out_data_o  = main_q;
            assign in_xfer     = in_valid_i && ready_q;
            assign out_xfer    = out_valid_o && out_ready_i;

            always_comb begin
                state_d = state_q;
                main_d  = main_q;
                skid_d  = skid_q;
                case (state_q)
                    RS_EMPTY: begin
                        if (in_xfer) begin
                            main_d  = in_data_i;
                            state_d = RS_BUSY;
                        end
                    end
                    RS_BUSY: begin
                        if (in_xfer && !out_xfer) begin
                            skid_d  = in_data_i;
                            state_d = RS_FULLST;
                        end else if (out_xfer && !in_xfer) begin
                            state_d = RS_EMPTY;
                        end else if (in_xfer && out_xfer) begin
                            main_d  = in_data_i;
                        end
                    end
                    RS_FULLST: begin
                        // Skid promotes to main; ready reopens on the following cycle.
                        if (out_xfer) begin
                            main_d  = skid_q;
                            state_d = RS_BUSY;
                        end
                    end
                    default: state_d = RS_EMPTY;
                endcase
                if (flush_i) state_d = RS_EMPTY;
            end

            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    state_q <= RS_EMPTY;
                    ready_q <= 1'b1;
                    main_q  <= '0;
                    skid_q  <= '0;
                end else begin
                    state_q <= state_d;
                    ready_q <= (state_d != RS_FULLST);
                    main_q  <= main_d;
                    skid_q  <= skid_d;
                end
            end
        end
    endgenerate

endmodule

// File: rtl/sv_pipeline_rs.sv
// Multi-stage valid/ready register slice (bypass / forward / full) with a beat occupancy counter.
// Optional synchronous flush input enabled by defining SV_PIPELINE_RS_FLUSH_EN.
module sv_pipeline_rs
    import sv_pipeline_pkg::*;
#(
    parameter int       WIDTH  = 32,
    parameter int       STAGES = 1,
    parameter rs_mode_e MODE   = RS_FULL
) (
    input  logic                         clk,
    input  logic                         rst,
`ifdef SV_PIPELINE_RS_FLUSH_EN
    input  logic                         flush,
`endif
    input  logic                         s_valid,
    output logic                         s_ready,
    input  logic [WIDTH-1:0]             s_data,
    output logic                         m_valid,
    input  logic                         m_ready,
    output logic [WIDTH-1:0]             m_data,
    output logic [occ_width(STAGES)-1:0] occupancy
);

    localparam int OW = occ_width(STAGES);

    logic flush_w;
`ifdef SV_PIPELINE_RS_FLUSH_EN
    assign flush_w = flush;
`else
    assign flush_w = 1'b0;
`endif

    generate
        if (MODE == RS_BYPASS) begin : g_bypass
            assign m_valid   = s_valid;
            assign m_data    = s_data;
            assign s_ready   = m_ready;
            assign occupancy = '0;
        end else begin : g_pipe
            localparam logic [OW-1:0] ONE = OW'(1);

            logic [STAGES:0]  vld;
            logic [STAGES:0]  rdy;
            logic [WIDTH-1:0] dat [STAGES+1];
            logic [OW-1:0]    occ_q, occ_d;
            logic             s_xfer, m_xfer;

            // Upstream sees no ready during reset or flush, so nothing is accepted then.
            assign s_ready       = rdy[0] && !rst && !flush_w;
            assign vld[0]        = s_valid && s_ready;
            assign dat[0]        = s_data;
            assign rdy[STAGES]   = m_ready;
            assign m_valid       = vld[STAGES];
            assign m_data        = dat[STAGES];

            for (genvar i = 0; i < STAGES; i++) begin : g_stage
                sv_rs_stage #(
                    .WIDTH (WIDTH),
                    .MODE  (MODE)
                ) u_stage (
                    .clk_i       (clk),
                    .rst_i       (rst),
                    .flush_i     (flush_w),
                    .in_valid_i  (vld[i]),
                    .in_ready_o  (rdy[i]),
                    .in_data_i   (dat[i]),
                    .out_valid_o (vld[i+1]),
                    .out_ready_i (rdy[i+1]),
                    .out_data_o  (dat[i+1])
                );
            end

            assign s_xfer    = s_valid && s_ready;
            assign m_xfer    = m_valid && m_ready;
            assign occupancy = occ_q;

            always_comb begin
                occ_d = occ_q;
                if (s_xfer && !m_xfer) begin
                    occ_d = occ_q + ONE;
                end else if (m_xfer && !s_xfer) begin
                    occ_d = occ_q - ONE;
                end
                if (flush_w) occ_d = '0;
            end

            always_ff @(posedge clk) begin
                if (rst) begin
                    occ_q <= '0;
                end else begin
                    occ_q <= occ_d;
                end
            end
        end
    endgenerate

endmodule
